// File: rtl/edge_scan_ctrl_pkg.sv
// Shared types and constants for the edge-detection scan sequencer.
package edge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLR     = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    // 3x3 kernel tap index range
    localparam int K_FIRST = 0;
    localparam int K_LAST  = 2;

    localparam int IMG_W_DEF = 64;
    localparam int IMG_H_DEF = 64;

endpackage

// File: rtl/edge_scan_ctrl_if.sv
// Word-addressed read/write memory port of the scan sequencer.
// The master drives the requests; the slave (memory fabric) drives stalls and read-valid.
interface edge_scan_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              rd_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic              rd_waitreq_i;
    logic              rd_valid_i;
    logic              wr_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic              wr_waitreq_i;

    modport master (
        output rd_o, rd_addr_o, wr_o, wr_addr_o,
        input  rd_waitreq_i, rd_valid_i, wr_waitreq_i
    );

    modport slave (
        input  rd_o, rd_addr_o, wr_o, wr_addr_o,
        output rd_waitreq_i, rd_valid_i, wr_waitreq_i
    );
endinterface

// File: rtl/edge_scan_ctrl_scan_counter2d.sv
// Two-axis raster counter: a runs fastest, b steps when a wraps.
// clr loads the start corner, last flags the end corner.
module scan_counter2d #(
    parameter int A_W     = 2,
    parameter int B_W     = 2,
    parameter int A_START = 0,
    parameter int A_END   = 2,
    parameter int B_START = 0,
    parameter int B_END   = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clr,
    input  logic           inc,
    output logic [A_W-1:0] a,
    output logic [B_W-1:0] b,
    output logic           last
);
    localparam logic [A_W-1:0] A_S   = A_W'(A_START);
    localparam logic [A_W-1:0] A_E   = A_W'(A_END);
    localparam logic [B_W-1:0] B_S   = B_W'(B_START);
    localparam logic [B_W-1:0] B_E   = B_W'(B_END);
    localparam logic [A_W-1:0] A_ONE = A_W'(1);
    localparam logic [B_W-1:0] B_ONE = B_W'(1);

    // clear has priority over increment; b wraps back to its start after the end corner
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            a <= '0;
            b <= '0;
        end else if (clr) begin
            a <= A_S;
            b <= B_S;
        end else if (inc) begin
            if (a == A_E) begin
                a <= A_S;
                b <= (b == B_E) ? B_S : b + B_ONE;
            end else begin
                a <= a + A_ONE;
            end
        end
    end

    assign last = (a == A_E) && (b == B_E);

endmodule

// File: rtl/edge_scan_ctrl.sv
// Edge-detection scan sequencer: walks the interior pixels of the source image,
// issues the nine neighbour reads per pixel, strobes the kernel datapath and
// writes one result per pixel.
//
//   state   | meaning
//   IDLE    | waiting for start_i
//   CLR     | clear accumulator, taps at (0,0)
//   RD_REQ  | read request for current tap, held through stalls
//   RD_WAIT | waiting for read data; accumulate on rd_valid_i
//   WRITE   | write request for current pixel, held through stalls
//   DONE    | one-cycle frame-complete pulse
module edge_scan_ctrl
    import edge_pkg::*;
#(
    parameter int                IMG_W    = IMG_W_DEF,
    parameter int                IMG_H    = IMG_H_DEF,
    parameter int                X_W      = 6,
    parameter int                Y_W      = 6,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] SRC_BASE = '0,
    parameter logic [ADDR_W-1:0] DST_BASE = 'h4000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    output logic                    busy_o,
    output logic                    done_o,
    edge_scan_ctrl_if.master        mem,
    output logic                    acc_clr_o,
    output logic                    acc_en_o,
    output logic [1:0]              kx_o,
    output logic [1:0]              ky_o
);
    localparam logic [ADDR_W-1:0] ROW_SRC = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_DST = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    state_t            state_q, state_d;
    logic              abort_q;
    logic              pix_clr, pix_inc, pix_last;
    logic              tap_clr, tap_inc, tap_last;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [1:0]        kx, ky;
    logic [ADDR_W-1:0] src_addr, dst_addr;

    scan_counter2d #(
        .A_W(X_W), .B_W(Y_W),
        .A_START(1), .A_END(IMG_W - 2),
        .B_START(1), .B_END(IMG_H - 2)
    ) u_pix (
        .clk_i(clk_i), .rst_i(rst_i), .clr(pix_clr), .inc(pix_inc),
        .a(x), .b(y), .last(pix_last)
    );

    scan_counter2d #(
        .A_W(2), .B_W(2),
        .A_START(K_FIRST), .A_END(K_LAST),
        .B_START(K_FIRST), .B_END(K_LAST)
    ) u_tap (
        .clk_i(clk_i), .rst_i(rst_i), .clr(tap_clr), .inc(tap_inc),
        .a(kx), .b(ky), .last(tap_last)
    );

    // state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // abort request is remembered for the rest of the frame and dropped once idle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                 abort_q <= 1'b0;
        else if (state_q == IDLE)   abort_q <= 1'b0;
        else if (abort_i)           abort_q <= 1'b1;
    end

    // neighbour and result addresses from the counter registers, modulo 2**ADDR_W
    always_comb begin
        src_addr = SRC_BASE
                 + (ADDR_W'(y) + ADDR_W'(ky) - ONE) * ROW_SRC
                 + ADDR_W'(x) + ADDR_W'(kx) - ONE;
        dst_addr = DST_BASE + (ADDR_W'(y) - ONE) * ROW_DST + ADDR_W'(x) - ONE;
    end

    // next-state and strobes; requests are only dropped after their handshake
    always_comb begin
        state_d   = state_q;
        pix_clr   = 1'b0;
        pix_inc   = 1'b0;
        tap_clr   = 1'b0;
        tap_inc   = 1'b0;
        acc_clr_o = 1'b0;
        acc_en_o  = 1'b0;
        mem.rd_o  = 1'b0;
        mem.wr_o  = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    pix_clr = 1'b1;
                    tap_clr = 1'b1;
                    state_d = CLR;
                end
            end
            CLR: begin
                acc_clr_o = 1'b1;
                state_d   = RD_REQ;
            end
            RD_REQ: begin
                mem.rd_o = 1'b1;
                if (!mem.rd_waitreq_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem.rd_valid_i) begin
                    acc_en_o = 1'b1;
                    if (tap_last) begin
                        state_d = WRITE;
                    end else begin
                        tap_inc = 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            WRITE: begin
                mem.wr_o = 1'b1;
                if (!mem.wr_waitreq_i) begin
                    tap_clr = 1'b1;
                    if (pix_last) begin
                        state_d = DONE;
                    end else if (abort_q || abort_i) begin
                        state_d = IDLE;
                    end else begin
                        pix_inc = 1'b1;
                        state_d = CLR;
                    end
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o        = (state_q != IDLE);
    assign mem.rd_addr_o = (state_q == RD_REQ) ? src_addr : '0;
    assign mem.wr_addr_o = (state_q == WRITE)  ? dst_addr : '0;
    assign kx_o          = kx;
    assign ky_o          = ky;

endmodule
